ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer placed in front of the 256x16 data RAM of the single-cycle RISC. It shares the RAM's single address/write port between the CPU data port (port 0) and a program/debug loader port (port 1). It issues at most one access per cycle and returns registered read data with a fixed one-cycle latency. Locked bursts are supported, with a bounded lock length so the other port cannot be starved.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (256 words)
- DATA_W, 16, RAM word width
- MAX_LOCK, 16, maximum consecutive granted cycles a locked owner may hold the RAM

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this access
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access performed this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid, one cycle pulse
- rdata0 / rdata1  out  DATA_W  registered read data
- ram_addr  out  ADDR_W  to RAM Addr
- ram_we  out  1  to RAM Write_En
- ram_d  out  DATA_W  to RAM D
- ram_o  in  DATA_W  from RAM O, combinational read of ram_addr

## Operation
- FSM states:
  - IDLE: arbitrate.
  - OWN0 / OWN1: the locked port owns the RAM.
- IDLE behaviour:
  - Single requester is granted.
  - Both requesting: the port not granted last wins (round-robin via `last` register).
  - Granted with lock=1 → OWNx, lock_cnt=1.
- OWNx behaviour:
  - Only port x can be granted; the other port's gnt stays 0 even if it requests.
  - Owner granted with lock=0 → IDLE.
  - Owner req=0 → IDLE; no grant that cycle.
  - lock_cnt reaches MAX_LOCK → forced IDLE after that access, and `last`=x, so a waiting other port wins next.
- Mux: ram_addr/ram_d/ram_we come from the granted port. With no grant: ram_we=0, ram_addr=addr0, ram_d=0.
- ram_we = gnt & we of the granted port; the RAM writes on that clock edge.
- A granted read captures ram_o into rdata_x at the edge; rvalid_x=1 for the next cycle only. rdata_x holds its value otherwise.
- Writes produce no rvalid.
- lock_cnt saturates at MAX_LOCK, width clog2(MAX_LOCK+1).

## Timing
- Reset values:
  - state=IDLE, last=1 (port 0 wins first contention), lock_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - gnt0/1=0 and ram_we=0 while rst=1.
- Grant latency: 0 cycles when uncontended; at most 1 cycle under round-robin contention; at most MAX_LOCK+1 cycles under a lock.
- Read latency: rvalid one cycle after gnt.
- Back-to-back grants to the same port are allowed every cycle when the other port is idle. Throughput is one access per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- rst mid-lock: FSM returns to IDLE. A pending rvalid is dropped (0 after reset edge).
- Requesters must hold req/we/addr/wdata/lock stable until gnt; changes before gnt are legal but simply re-evaluated.

## Configuration
- RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins contention in IDLE; the `last` register is unused. Locking and MAX_LOCK still apply; a forced release hands the next cycle to port 1 if it requests.
- Not defined: round-robin as above.

## Structure
- Shared package ram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {IDLE, OWN0, OWN1}.
  - Port index constants P_CPU=0, P_LDR=1.
- One sub-module, ram_arb_pick: combinational pick of the winner from req0, req1, last, state. This is where the fixed-priority macro applies.
- FSM, lock counter, data mux and read registers live in ram_arbiter. The RAM itself is instantiated by the parent, not inside.

## Test plan
- Reset: rst=1 for 2 cycles with both req=1 → gnt0=gnt1=0, ram_we=0, rvalid=0, rdata=0000.
- Single writes then reads: port 0 writes 8'h12←16'h1234 and 8'h34←16'h3456, then reads both → rvalid0 a cycle after each gnt0 with rdata0=1234, then 3456.
- Contention: both ports read every cycle, different addresses → gnt alternates 0,1,0,1; each rvalid matches its own port's data. With RAM_ARB_FIXED_PRIO_EN, gnt0 every cycle.
- Lock burst: port 1 writes 4 words F0..F3 with lock=1 (lock=0 on last) while port 0 requests → port 0 blocked 4 cycles, granted on cycle 5.
- Lock overrun: port 1 holds lock=1 for 20 cycles, MAX_LOCK=16 → forced release after 16 grants, gnt0 next cycle.
- Reset mid-lock: assert rst during OWN1 with a read in flight → rvalid1=0 after reset; the next contention grants port 0 first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the RAM arbiter.
// RAM_ARB_FIXED_PRIO_EN: port 0 always wins IDLE contention instead of round-robin.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  logic   last,
  input  state_e state,
  output logic   gnt0,
  output logic   gnt1
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      OWN0: gnt0 = req0;
      OWN1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          gnt0 = 1'b1;
`else
          gnt0 = (last != P_CPU);
          gnt1 = (last == P_CPU);
`endif
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data RAM, with bounded locked bursts.
// RAM_ARB_FIXED_PRIO_EN: fixed port-0 priority; a forced release of port 0 hands over to port 1.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_o
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d, cnt_inc;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pick0, pick1;

  ram_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .state (state_q),
    .gnt0  (pick0),
    .gnt1  (pick1)
  );

  assign gnt0 = pick0 & ~rst;
  assign gnt1 = pick1 & ~rst;

  always_comb begin
    ram_addr = gnt1 ? addr1 : addr0;
    ram_d    = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
    ram_we   = (gnt0 & we0) | (gnt1 & we1);
  end

  assign cnt_inc = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      OWN0: begin
        if (!gnt0) begin
          state_d = IDLE;
        end else begin
          last_d     = P_CPU;
          lock_cnt_d = cnt_inc;
          if (!lock0 || cnt_inc == CNT_MAX) state_d = IDLE;
`ifdef RAM_ARB_FIXED_PRIO_EN
          // Fixed priority would hand port 0 the RAM straight back; pass it to a waiting port 1.
          if (lock0 && cnt_inc == CNT_MAX && req1) begin
            state_d    = OWN1;
            lock_cnt_d = '0;
          end
`endif
        end
      end
      OWN1: begin
        if (!gnt1) begin
          state_d = IDLE;
        end else begin
          last_d     = P_LDR;
          lock_cnt_d = cnt_inc;
          if (!lock1 || cnt_inc == CNT_MAX) state_d = IDLE;
        end
      end
      default: begin
        lock_cnt_d = '0;
        if (gnt0) begin
          last_d = P_CPU;
          if (lock0 && MAX_LOCK > 1) begin
            state_d    = OWN0;
            lock_cnt_d = CNT_W'(1);
          end
        end else if (gnt1) begin
          last_d = P_LDR;
          if (lock1 && MAX_LOCK > 1) begin
            state_d    = OWN1;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? ram_o : rdata0_q;
    rdata1_d  = rvalid1_d ? ram_o : rdata1_q;
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= P_LDR;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 256x16 RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_d, ram_o;
  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_o(ram_o)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_o = mem[ram_addr];

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0; wdata1 = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1; lock0 = 0; lock1 = 0;
    addr0 = 8'h01; addr1 = 8'h02; wdata0 = 16'h1111; wdata1 = 16'h2222;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++; if ({gnt0, gnt1, ram_we, rvalid0, rvalid1} !== 5'b0) begin
        n_err++; $display("FAIL reset_ctrl c%0d: got %b want 00000", c, {gnt0, gnt1, ram_we, rvalid0, rvalid1}); end
      n_cmp++; if ({rdata0, rdata1} !== 32'h0) begin
        n_err++; $display("FAIL reset_rdata c%0d: got %h want 00000000", c, {rdata0, rdata1}); end
    end
    @(negedge clk); rst = 0; idle_inputs();
  endtask

  task automatic test_single_rw();
    @(negedge clk); req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 16'h1234; #1;
    n_cmp++; if ({gnt0, gnt1, ram_we, ram_addr, ram_d} !== {3'b101, 8'h12, 16'h1234}) begin
      n_err++; $display("FAIL wr12: got %b %h %h want 101 12 1234", {gnt0, gnt1, ram_we}, ram_addr, ram_d); end
    @(negedge clk); addr0 = 8'h34; wdata0 = 16'h3456; #1;
    n_cmp++; if ({gnt0, gnt1, ram_we, ram_addr, ram_d} !== {3'b101, 8'h34, 16'h3456}) begin
      n_err++; $display("FAIL wr34: got %b %h %h want 101 34 3456", {gnt0, gnt1, ram_we}, ram_addr, ram_d); end
    @(negedge clk); we0 = 0; addr0 = 8'h12; #1;
    n_cmp++; if ({gnt0, ram_we, rvalid0} !== 3'b100) begin
      n_err++; $display("FAIL rd12_issue: got %b want 100", {gnt0, ram_we, rvalid0}); end
    @(negedge clk); addr0 = 8'h34; #1;
    n_cmp++; if ({gnt0, rvalid0, rdata0} !== {2'b11, 16'h1234}) begin
      n_err++; $display("FAIL rd12_data: got %b %h want 11 1234", {gnt0, rvalid0}, rdata0); end
    @(negedge clk); we0 = 1; addr0 = 8'h55; wdata0 = 16'hABCD; #1;
    n_cmp++; if ({gnt0, ram_we, rvalid0, rdata0} !== {3'b111, 16'h3456}) begin
      n_err++; $display("FAIL rd34_data: got %b %h want 111 3456", {gnt0, ram_we, rvalid0}, rdata0); end
    @(negedge clk); we0 = 0; #1;
    n_cmp++; if ({gnt0, ram_we, rvalid0} !== 3'b100) begin
      n_err++; $display("FAIL raw_issue: got %b want 100", {gnt0, ram_we, rvalid0}); end
    @(negedge clk); req0 = 0; #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 16'hABCD}) begin
      n_err++; $display("FAIL raw_data: got %b %h want 1 abcd", rvalid0, rdata0); end
    n_cmp++; if ({gnt0, gnt1, ram_we, ram_addr, ram_d} !== {3'b000, 8'h55, 16'h0000}) begin
      n_err++; $display("FAIL nogrant_mux: got %b %h %h want 000 55 0000", {gnt0, gnt1, ram_we}, ram_addr, ram_d); end
    @(negedge clk); req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 16'h4040; #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b0, 16'hABCD}) begin
      n_err++; $display("FAIL rdata_hold: got %b %h want 0 abcd", rvalid0, rdata0); end
    n_cmp++; if ({gnt0, gnt1, ram_we, ram_addr, ram_d} !== {3'b011, 8'h40, 16'h4040}) begin
      n_err++; $display("FAIL wr40_p1: got %b %h %h want 011 40 4040", {gnt0, gnt1, ram_we}, ram_addr, ram_d); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin
      n_err++; $display("FAIL wr_no_rvalid: got %b want 00", {rvalid0, rvalid1}); end
  endtask

  task automatic test_contention();
    logic exp_g0;
    logic prev_g0 = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        req0 = 1; we0 = 0; addr0 = 8'h12; req1 = 1; we1 = 0; addr1 = 8'h40;
      end else idle_inputs();
      #1;
      if (k < 6) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g0 = 1'b1;
`else
        exp_g0 = (k % 2 == 0);
`endif
        n_cmp++; if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin
          n_err++; $display("FAIL cont_gnt k%0d: got %b%b want %b%b", k, gnt0, gnt1, exp_g0, ~exp_g0); end
      end
      if (k > 0) begin
        if (prev_g0) begin
          n_cmp++; if ({rvalid0, rvalid1, rdata0} !== {2'b10, 16'h1234}) begin
            n_err++; $display("FAIL cont_rd0 k%0d: got %b%b %h want 10 1234", k, rvalid0, rvalid1, rdata0); end
        end else begin
          n_cmp++; if ({rvalid0, rvalid1, rdata1} !== {2'b01, 16'h4040}) begin
            n_err++; $display("FAIL cont_rd1 k%0d: got %b%b %h want 01 4040", k, rvalid0, rvalid1, rdata1); end
        end
      end
      prev_g0 = exp_g0;
    end
  endtask

  task automatic test_lock_burst();
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      req1 = 1; we1 = 1; lock1 = (i != 3); addr1 = 8'hF0 + 8'(i); wdata1 = 16'hA5F0 + 16'(i);
      if (i > 0) begin req0 = 1; we0 = 0; addr0 = 8'h12; end
      #1;
      n_cmp++; if ({gnt0, gnt1, ram_we, ram_addr, ram_d} !== {3'b011, 8'hF0 + 8'(i), 16'hA5F0 + 16'(i)}) begin
        n_err++; $display("FAIL lock_wr i%0d: got %b %h %h want 011 %h %h", i, {gnt0, gnt1, ram_we}, ram_addr, ram_d,
                          8'hF0 + 8'(i), 16'hA5F0 + 16'(i)); end
    end
    @(negedge clk); req1 = 0; lock1 = 0; we1 = 0; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL lock_release: got %b%b want 10", gnt0, gnt1); end
    @(negedge clk); addr0 = 8'hF2; #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL lock_p0_rd: got %b %h want 1 1234", rvalid0, rdata0); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 16'hA5F2}) begin
      n_err++; $display("FAIL lock_mem_f2: got %b %h want 1 a5f2", rvalid0, rdata0); end
  endtask

  task automatic test_lock_overrun();
    int  n1 = 0;
    bit  p0_done = 0;
    logic [1:0] exp_g;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req1 = 1; we1 = 1; lock1 = (i != 19); addr1 = 8'h80 + 8'(n1); wdata1 = 16'h0800 + 16'(n1);
      req0 = (i >= 1) && !p0_done; we0 = 0; addr0 = 8'h12;
      #1;
      exp_g = (i == 16) ? 2'b10 : 2'b01;
      n_cmp++; if ({gnt0, gnt1} !== exp_g) begin
        n_err++; $display("FAIL overrun_gnt i%0d: got %b%b want %b", i, gnt0, gnt1, exp_g); end
      if (i == 17) begin
        n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 16'h1234}) begin
          n_err++; $display("FAIL overrun_rd0: got %b %h want 1 1234", rvalid0, rdata0); end
      end
      if (gnt1) n1++;
      if (gnt0) p0_done = 1;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk); req1 = 1; we1 = 0; lock1 = 1; addr1 = 8'h40; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL rml_gnt: got %b%b want 01", gnt0, gnt1); end
    @(negedge clk); #1;
    n_cmp++; if ({gnt1, rvalid1, rdata1} !== {2'b11, 16'h4040}) begin
      n_err++; $display("FAIL rml_inflight: got %b %h want 11 4040", {gnt1, rvalid1}, rdata1); end
    rst = 1; #1;
    n_cmp++; if ({gnt0, gnt1, ram_we} !== 3'b000) begin
      n_err++; $display("FAIL rml_rst_gate: got %b want 000", {gnt0, gnt1, ram_we}); end
    @(negedge clk); #1;
    n_cmp++; if ({rvalid1, rdata1} !== {1'b0, 16'h0000}) begin
      n_err++; $display("FAIL rml_rvalid_drop: got %b %h want 0 0000", rvalid1, rdata1); end
    rst = 0; req0 = 1; we0 = 0; addr0 = 8'h12; lock1 = 0; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rml_first: got %b%b want 10", gnt0, gnt1); end
    @(negedge clk); #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rml_second: got %b%b want 10", gnt0, gnt1); end
`else
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL rml_second: got %b%b want 01", gnt0, gnt1); end
`endif
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_rw();
    test_contention();
    test_lock_burst();
    test_lock_overrun();
    test_reset_mid_lock();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
